// File: rtl/div_pkg.sv
// div_pkg: shared divider front-end types and constants (3-bit state encoding, default width, divide-by-zero quotient)
package div_pkg;
  localparam int DATAWIDTH = 32;
  localparam logic [DATAWIDTH-1:0] DBZ_QUO = '1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ABORT = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate; ports in (value), neg (negate when 1), out (result)
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);
  assign out = neg ? -in : in;
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: divider issue/stall/sign-correction front end; ports clk/rst, start/signed_op/op_a/op_b/annul from EX, stall/result_vld/quo/rem/dbz to EX, div_en/div_ready/div_dividend/div_divisor/div_quotient/div_remainder/div_vld to the divider; DIV_SIGNED_EN enables signed DIV
module div_issue_ctrl #(
  parameter int DATAWIDTH = div_pkg::DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [DATAWIDTH-1:0] op_a,
  input  logic [DATAWIDTH-1:0] op_b,
  input  logic                 annul,
  output logic                 stall,
  output logic                 result_vld,
  output logic [DATAWIDTH-1:0] quo,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 dbz,
  output logic                 div_en,
  input  logic                 div_ready,
  output logic [DATAWIDTH-1:0] div_dividend,
  output logic [DATAWIDTH-1:0] div_divisor,
  input  logic [DATAWIDTH-1:0] div_quotient,
  input  logic [DATAWIDTH-1:0] div_remainder,
  input  logic                 div_vld
);
  import div_pkg::*;
  localparam int MSB = DATAWIDTH - 1;
  state_t state, state_nxt;
  logic sgn, neg_a, neg_b, sign_a, sign_q;
  logic [DATAWIDTH-1:0] mag_a, mag_b, fix_q, fix_r;
`ifdef DIV_SIGNED_EN
  assign sgn = signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn = 1'b0;
`endif
  assign neg_a = sgn & op_a[MSB];
  assign neg_b = sgn & op_b[MSB];
  div_sign_fix #(.W(DATAWIDTH)) u_mag_a (.in(op_a), .neg(neg_a), .out(mag_a));
  div_sign_fix #(.W(DATAWIDTH)) u_mag_b (.in(op_b), .neg(neg_b), .out(mag_b));
  div_sign_fix #(.W(DATAWIDTH)) u_fix_q (.in(div_quotient), .neg(sign_q), .out(fix_q));
  div_sign_fix #(.W(DATAWIDTH)) u_fix_r (.in(div_remainder), .neg(sign_a), .out(fix_r));
  assign stall = ((state == IDLE || state == ABORT) && start) || state == ISSUE || state == WAIT;
  assign result_vld = state == DONE;
  assign div_en = state == ISSUE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = !start ? IDLE : (op_b == '0) ? DONE : ISSUE;
      // annul coinciding with an accepted launch still leaves a result in flight, so it must drain
      ISSUE: state_nxt = annul ? (div_ready ? ABORT : IDLE) : (div_ready ? WAIT : ISSUE);
      WAIT:  state_nxt = annul ? (div_vld ? IDLE : ABORT) : (div_vld ? DONE : WAIT);
      ABORT: state_nxt = div_vld ? IDLE : ABORT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      quo          <= '0;
      rem          <= '0;
      dbz          <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      sign_a       <= 1'b0;
      sign_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && op_b == '0) begin
        quo <= DATAWIDTH'(DBZ_QUO);
        rem <= op_a;
        dbz <= 1'b1;
      end else if (state == IDLE && start) begin
        div_dividend <= mag_a;
        div_divisor  <= mag_b;
        sign_a       <= neg_a;
        sign_q       <= neg_a ^ neg_b;
      end
      if (state == WAIT && div_vld && !annul) begin
        quo <= fix_q;
        rem <= fix_r;
        dbz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed self-checking bench for div_issue_ctrl with a fixed-latency divider model
module tb_div_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, signed_op = 1'b0, annul = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic stall, result_vld, dbz, div_en;
  logic [31:0] quo, rem, div_dividend, div_divisor;
  logic div_ready, div_vld;
  logic [31:0] div_quotient, div_remainder;
  logic m_busy;
  int m_cnt;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .annul(annul), .stall(stall),
    .result_vld(result_vld), .quo(quo), .rem(rem), .dbz(dbz),
    .div_en(div_en), .div_ready(div_ready), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_vld(div_vld)
  );
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt <= 0;
      div_vld <= 1'b0;
      div_ready <= 1'b1;
      div_quotient <= '0;
      div_remainder <= '0;
    end else begin
      div_vld <= 1'b0;
      if (!m_busy) begin
        if (div_en && div_ready) begin
          m_busy <= 1'b1;
          div_ready <= 1'b0;
          m_cnt <= 34;
          div_quotient <= div_dividend / div_divisor;
          div_remainder <= div_dividend % div_divisor;
        end
      end else if (m_cnt == 1) begin
        m_busy <= 1'b0;
        div_ready <= 1'b1;
        div_vld <= 1'b1;
      end else m_cnt <= m_cnt - 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int elat, input logic [31:0] edvd);
    int cyc = 0;
    logic saw_en = 1'b0, gap = 1'b0;
    signed_op = s;
    op_a = a;
    op_b = b;
    start = 1'b1;
    #1;
    check({tag, "_stall_req"}, stall, 1);
    while (!result_vld && cyc < 200) begin
      tick();
      cyc++;
      saw_en |= div_en;
      if (!result_vld && !stall) gap = 1'b1;
    end
    check({tag, "_latency"}, cyc, elat);
    check({tag, "_stall_done"}, stall, 0);
    check({tag, "_stall_gap"}, gap, 0);
    check({tag, "_quo"}, quo, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_dbz"}, dbz, edbz);
    check({tag, "_div_en_seen"}, saw_en, !edbz);
    if (!edbz) check({tag, "_dividend"}, div_dividend, edvd);
    start = 1'b0;
    tick();
    check({tag, "_vld_drop"}, result_vld, 0);
    check({tag, "_no_relaunch"}, stall | div_en, 0);
  endtask
  initial begin
    logic stale;
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_vld", result_vld, 0);
    check("rst_dbz", dbz, 0);
    check("rst_div_en", div_en, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_divisor", div_divisor, 0);
    rst = 1'b0;
    tick();
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 37, 32'd100);
`ifdef DIV_SIGNED_EN
    run_op("sneg100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 37, 32'd100);
    run_op("s100_neg7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 37, 32'd100);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 37, 32'h80000000);
`else
    run_op("sneg100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 37, 32'hFFFFFF9C);
    run_op("s100_neg7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 1'b0, 37, 32'd100);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 37, 32'h80000000);
`endif
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 32'd0);
    run_op("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 32'd0);
    run_op("sneg5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1, 32'd0);
    signed_op = 1'b0;
    op_a = 32'd100;
    op_b = 32'd7;
    start = 1'b1;
    repeat (5) tick();
    check("annul_pre_stall", stall, 1);
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul_abort_idle_stall", stall | div_en, 0);
    op_a = 32'd9;
    op_b = 32'd2;
    start = 1'b1;
    #1;
    check("annul_abort_stall", stall, 1);
    stale = 1'b0;
    cyc = 0;
    while (!result_vld && cyc < 200) begin
      tick();
      cyc++;
      if (quo == 32'd14 || rem == 32'd2) stale = 1'b1;
      if (!result_vld && !stall) stale = 1'b1;
    end
    check("annul_done", result_vld, 1);
    check("annul_stale", stale, 0);
    check("annul_quo", quo, 32'd4);
    check("annul_rem", rem, 32'd1);
    check("annul_dbz", dbz, 0);
    start = 1'b0;
    tick();
    op_a = 32'd100;
    op_b = 32'd7;
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    check("rstmid_pre_stall", stall, 1);
    rst = 1'b1;
    #1;
    check("rstmid_stall", stall, 0);
    check("rstmid_vld", result_vld, 0);
    check("rstmid_dbz", dbz, 0);
    check("rstmid_div_en", div_en, 0);
    check("rstmid_quo", quo, 0);
    check("rstmid_rem", rem, 0);
    check("rstmid_dividend", div_dividend, 0);
    check("rstmid_divisor", div_divisor, 0);
    tick();
    rst = 1'b0;
    tick();
    run_op("u20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 37, 32'd20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
